// File: rtl/fp_arbiter.sv
// Fixed-priority queue arbiter: registered grant with valid/ready handshake.
// Define FP_ARBITER_RR_TIEBREAK_EN for round-robin among equal-priority queues.
module fp_arbiter #(
    parameter int  NUMBER_OF_QUEUES = 4,
    parameter int  PRIORITY_SIZE    = 32,
    localparam int SELECTION_SIZE   = $clog2(NUMBER_OF_QUEUES)
) (
    input  logic                                             clock,
    input  logic                                             reset,
    input  logic [NUMBER_OF_QUEUES-1:0][PRIORITY_SIZE-1:0]   priorities,
    input  logic [NUMBER_OF_QUEUES-1:0]                      empty,
    input  logic                                             ready,
    output logic                                             valid,
    output logic [SELECTION_SIZE-1:0]                        selection,
    output logic [SELECTION_SIZE-1:0]                        last_grant
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                    state, state_nxt;
    logic [SELECTION_SIZE-1:0] sel_nxt, last_nxt;
    logic [SELECTION_SIZE-1:0] winner;
    logic [PRIORITY_SIZE-1:0]  best;
    logic                      has_winner;
    logic                      handshake;

    assign valid     = (state == GRANT);
    assign handshake = valid && ready;

`ifdef FP_ARBITER_RR_TIEBREAK_EN
    // The grant being accepted this cycle counts as the most recent one,
    // otherwise back-to-back tied grants would repeat the same queue.
    logic [SELECTION_SIZE-1:0] rr_ptr;
    logic                      rr_found;
    int                        idx;
    assign rr_ptr = handshake ? selection : last_grant;
`endif

    always_comb begin
        has_winner = 1'b0;
        best       = '0;
        winner     = '0;
        // Strict compare keeps the lowest index among ties.
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (!empty[i] && (!has_winner || priorities[i] > best)) begin
                has_winner = 1'b1;
                best       = priorities[i];
                winner     = SELECTION_SIZE'(i);
            end
        end
`ifdef FP_ARBITER_RR_TIEBREAK_EN
        rr_found = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NUMBER_OF_QUEUES; k++) begin
            idx = (int'(rr_ptr) + k) % NUMBER_OF_QUEUES;
            if (!rr_found && !empty[idx] && priorities[idx] == best) begin
                rr_found = 1'b1;
                winner   = SELECTION_SIZE'(idx);
            end
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = selection;
        last_nxt  = last_grant;
        case (state)
            IDLE: begin
                if (has_winner) begin
                    state_nxt = GRANT;
                    sel_nxt   = winner;
                end
            end
            GRANT: begin
                if (ready) begin
                    last_nxt = selection;
                    if (has_winner) sel_nxt = winner;
                    else            state_nxt = IDLE;
                end else if (empty[selection]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            selection  <= '0;
            last_grant <= SELECTION_SIZE'(NUMBER_OF_QUEUES - 1);
        end else begin
            state      <= state_nxt;
            selection  <= sel_nxt;
            last_grant <= last_nxt;
        end
    end

endmodule
